// File: rtl/bmu_pipe.sv
// bmu_pipe: branch metrics for one N-bit received symbol against all 2^N expected patterns,
// hard or soft decision, per-bit erasure masking, metrics saturated to Wb bits.
// Two-register pipeline (S1 capture, S2 metric); valid/ready on both sides, at most 2 symbols held.
module bmu_pipe #(
  parameter int N  = 2,
  parameter int Q  = 3,
  parameter int Wb = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode_soft,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*Q-1:0]        rx_soft,
  input  logic [N-1:0]          rx_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(2**N)*Wb-1:0]  bm,
  output logic [15:0]           sym_cnt
);

  localparam int NP   = 2 ** N;
  localparam int RMAX = (1 << Q) - 1;
  // Width that holds the worst-case unsaturated sum without wrapping.
  localparam int SW   = $clog2(N * RMAX + 1);
  localparam int BMAX = (1 << Wb) - 1;

  // Stage 1: captured symbol, mask and mode.
  logic             s1_valid;
  logic [N*Q-1:0]   s1_rx;
  logic [N-1:0]     s1_mask;
  logic             s1_mode;

  logic             s2_adv;
  logic             accept;
  logic             deliver;

  // Metric computation scratch.
  logic [(2**N)*Wb-1:0] bm_next;
  logic [SW-1:0]        sum;
  logic [Q-1:0]         r;
  logic [Q-1:0]         cost;
  logic                 e;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !rst && (!s1_valid || s2_adv);
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid && out_ready;

  // Branch metrics of the S1 symbol for every expected pattern, saturated.
  always_comb begin
    bm_next = '0;
    sum     = '0;
    r       = '0;
    cost    = '0;
    e       = 1'b0;
    for (int p = 0; p < NP; p++) begin
      sum = '0;
      for (int i = 0; i < N; i++) begin
        r    = s1_rx[i*Q +: Q];
        e    = p[i];
        cost = '0;
        if (!s1_mask[i]) begin
          if (s1_mode) begin
            // Distance from the received level to the expected extreme.
            cost = e ? (Q'(RMAX) - r) : r;
          end else begin
            // Hard decision is the MSB of the soft value.
            cost[0] = r[Q-1] ^ e;
          end
        end
        sum = sum + SW'(cost);
      end
      if (int'(sum) > BMAX) begin
        bm_next[p*Wb +: Wb] = Wb'(BMAX);
      end else begin
        bm_next[p*Wb +: Wb] = Wb'(sum);
      end
    end
  end

  // S1: capture on accept; empties when its content moves into S2.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_rx    <= '0;
      s1_mask  <= '0;
      s1_mode  <= 1'b0;
    end else begin
      s1_valid <= accept || (s1_valid && !s2_adv);
      if (accept) begin
        s1_rx   <= rx_soft;
        s1_mask <= rx_mask;
        s1_mode <= mode_soft;
      end
    end
  end

  // S2: register metrics when free or draining; bm holds when no new symbol arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      bm        <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        bm <= bm_next;
      end
    end
  end

  // Delivered-symbol counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_cnt <= '0;
    end else if (deliver) begin
      sym_cnt <= sym_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_bmu_pipe.sv
// tb_bmu_pipe: table-driven check of bmu_pipe (N=2, Q=3) at Wb=4 and a saturating Wb=3 copy,
// plus hand sequences for latency, back-pressure, mid-run reset and counter wrap.
module tb_bmu_pipe;

  typedef struct packed {
    logic            mode;
    logic [2:0]      f1;
    logic [2:0]      f0;
    logic [1:0]      mask;
    logic [3:0][3:0] e4;
    logic [3:0][2:0] e3;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode_soft = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [5:0]  rx_soft = '0;
  logic [1:0]  rx_mask = '0;

  logic        in_ready, out_valid;
  logic [15:0] bm;
  logic [15:0] sym_cnt;
  logic        in_ready_s, out_valid_s;
  logic [11:0] bm_s;
  logic [15:0] sym_cnt_s;

  bmu_pipe #(.N(2), .Q(3), .Wb(4)) u_dut (
    .clk(clk), .rst(rst), .mode_soft(mode_soft), .in_valid(in_valid), .in_ready(in_ready),
    .rx_soft(rx_soft), .rx_mask(rx_mask), .out_valid(out_valid), .out_ready(out_ready),
    .bm(bm), .sym_cnt(sym_cnt)
  );

  bmu_pipe #(.N(2), .Q(3), .Wb(3)) u_sat (
    .clk(clk), .rst(rst), .mode_soft(mode_soft), .in_valid(in_valid), .in_ready(in_ready_s),
    .rx_soft(rx_soft), .rx_mask(rx_mask), .out_valid(out_valid_s), .out_ready(out_ready),
    .bm(bm_s), .sym_cnt(sym_cnt_s)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   ndlv = 0;
  int   cur_idx = 0;
  logic acc, dlv;
  int   q[$];
  vec_t vec [10];
  int   hl [5] = '{0, 4, 6, 8, 9};
  int   sl [5] = '{1, 2, 3, 5, 7};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic m, input int f1, input int f0, input logic [1:0] mk_mask,
                              input int a0, input int a1, input int a2, input int a3,
                              input int s0, input int s1, input int s2, input int s3);
    vec_t v;
    v.mode = m; v.f1 = 3'(f1); v.f0 = 3'(f0); v.mask = mk_mask;
    v.e4[0] = 4'(a0); v.e4[1] = 4'(a1); v.e4[2] = 4'(a2); v.e4[3] = 4'(a3);
    v.e3[0] = 3'(s0); v.e3[1] = 3'(s1); v.e3[2] = 3'(s2); v.e3[3] = 3'(s3);
    return v;
  endfunction

  task automatic drive(input int idx);
    cur_idx   = idx;
    mode_soft = vec[idx].mode;
    rx_soft   = {vec[idx].f1, vec[idx].f0};
    rx_mask   = vec[idx].mask;
  endtask

  // One clock: sample handshakes mid-cycle, score deliveries, record accepts.
  task automatic clk_cycle();
    int e;
    @(negedge clk);
    acc = in_valid && in_ready;
    dlv = out_valid && out_ready;
    chk("sat_handshake", {30'd0, in_ready_s, out_valid_s}, {30'd0, in_ready, out_valid});
    if (rst) begin
      q.delete();
      ndlv = 0;
    end else begin
      if (dlv) begin
        if (q.size() == 0) begin
          chk("spurious_out", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("bm_w4", {16'd0, bm}, {16'd0, vec[e].e4});
          chk("bm_w3", {20'd0, bm_s}, {20'd0, vec[e].e3});
        end
        ndlv++;
      end
      if (acc) q.push_back(cur_idx);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    in_valid = 1'b0;
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      if (q.size() == 1 && out_valid && ndlv == 65535) chk("cnt_ffff", {16'd0, sym_cnt}, 32'hFFFF);
      clk_cycle();
    end
    chk(name, q.size(), 32'd0);
  endtask

  initial begin
    logic [15:0] held;
    int k, d0;
    int bp [4] = '{1, 3, 7, 8};

    //            mode  f1 f0 mask   Wb=4 bm[0..3]    Wb=3 bm[0..3]
    vec[0] = mk(1'b0, 6, 2, 2'b00,  1,  2, 0, 1,   1, 2, 0, 1);
    vec[1] = mk(1'b1, 6, 2, 2'b00,  8, 11, 3, 6,   7, 7, 3, 6);
    vec[2] = mk(1'b1, 6, 2, 2'b10,  2,  5, 2, 5,   2, 5, 2, 5);
    vec[3] = mk(1'b1, 7, 7, 2'b00, 14,  7, 7, 0,   7, 7, 7, 0);
    vec[4] = mk(1'b0, 7, 7, 2'b00,  2,  1, 1, 0,   2, 1, 1, 0);
    vec[5] = mk(1'b1, 7, 7, 2'b11,  0,  0, 0, 0,   0, 0, 0, 0);
    vec[6] = mk(1'b0, 6, 2, 2'b01,  1,  1, 0, 0,   1, 1, 0, 0);
    vec[7] = mk(1'b1, 0, 5, 2'b00,  5,  2, 12, 9,  5, 2, 7, 7);
    vec[8] = mk(1'b0, 0, 5, 2'b00,  1,  0, 2, 1,   1, 0, 2, 1);
    vec[9] = mk(1'b0, 6, 2, 2'b11,  0,  0, 0, 0,   0, 0, 0, 0);

    // Power-on reset.
    #1;
    chk("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
    clk_cycle();
    clk_cycle();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_bm", {16'd0, bm}, 32'd0);
    chk("rst_sym_cnt", {16'd0, sym_cnt}, 32'd0);
    chk("rst_in_ready_high", {31'd0, in_ready}, 32'd1);

    // Latency: single symbol.
    out_ready = 1'b1;
    drive(0); in_valid = 1'b1;
    clk_cycle();
    in_valid = 1'b0;
    chk("lat_edge1_invalid", {31'd0, out_valid}, 32'd0);
    clk_cycle();
    chk("lat_edge2_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_edge2_bm", {16'd0, bm}, {16'd0, vec[0].e4});
    clk_cycle();
    chk("lat_sym_cnt", {16'd0, sym_cnt}, 32'd1);
    chk("bm_hold_after_deliver", {16'd0, bm}, {16'd0, vec[0].e4});

    // Full-throughput run through the whole table.
    for (int i = 0; i < 10; i++) begin
      drive(i); in_valid = 1'b1;
      clk_cycle();
      chk("table_accept", {31'd0, acc}, 32'd1);
    end
    drain("table_drain");
    chk("table_sym_cnt", {16'd0, sym_cnt}, 32'd11);

    // Back-pressure: 4 offered with out_ready low, only 2 fit.
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      drive(bp[k]); in_valid = 1'b1;
      clk_cycle();
      if (acc) k++;
      if (c == 4) held = bm;
    end
    chk("bp_accepted", k, 32'd2);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("bp_bm_stable", {16'd0, bm}, {16'd0, held});
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_on_release", {31'd0, in_ready}, 32'd1);
    d0 = ndlv;
    for (int c = 0; c < 4; c++) begin
      if (k < 4) begin drive(bp[k]); in_valid = 1'b1; end
      else in_valid = 1'b0;
      clk_cycle();
      if (acc) k++;
    end
    in_valid = 1'b0;
    chk("bp_one_per_cycle", ndlv - d0, 32'd4);
    chk("bp_sym_cnt", {16'd0, sym_cnt}, 32'd15);
    drain("bp_drain");

    // Reset with both stages full.
    out_ready = 1'b0;
    drive(1); in_valid = 1'b1; clk_cycle();
    drive(2); clk_cycle();
    in_valid = 1'b0;
    chk("mid_full", {30'd0, out_valid, in_ready}, 32'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    clk_cycle();
    rst = 1'b0;
    #1;
    chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_bm", {16'd0, bm}, 32'd0);
    chk("mid_sym_cnt", {16'd0, sym_cnt}, 32'd0);
    chk("mid_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    drive(3); in_valid = 1'b1;
    clk_cycle();
    in_valid = 1'b0;
    chk("mid_lat_edge1", {31'd0, out_valid}, 32'd0);
    clk_cycle();
    chk("mid_lat_edge2", {31'd0, out_valid}, 32'd1);
    chk("mid_lat_bm", {16'd0, bm}, {16'd0, vec[3].e4});
    clk_cycle();

    // Alternating hard/soft at full rate until the counter wraps.
    for (int n = 0; n < 65535; n++) begin
      drive((n % 2 == 0) ? hl[(n / 2) % 5] : sl[(n / 2) % 5]);
      in_valid = 1'b1;
      clk_cycle();
      if (!acc) chk("stream_accept", {31'd0, acc}, 32'd1);
    end
    drain("stream_drain");
    chk("wrap_sym_cnt", {16'd0, sym_cnt}, 32'd0);
    chk("wrap_sat_cnt", {16'd0, sym_cnt_s}, {16'd0, sym_cnt});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
